mem_arbiter: RTL and testbench

Arbitrates memory-bound requests from up to four requesters onto the single memory request channel, and routes memory responses back to the originating requester. It sits directly downstream of the instruction cache's miss path, which uses the `mem_req`/`grant`/`mem_rsp` interface. Its port 0 also serves the vector load/store path. Selection is round-robin with a one-entry output register toward memory. Responses are steered by the `access_id` prefix.

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_arbiter_rr_picker.sv | 27 ++
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory request/response channel, plus the access_id
// prefix constants that tie each requester to its arbiter port.
package mem_arbiter_pkg;

   localparam int ACCESS_ID_WIDTH   = 8;
   localparam int ADDR_WIDTH        = 32;
   localparam int DATA_WIDTH        = 32;
   localparam int MEM_ARB_MAX_PORTS = 4;

   // Top two access_id bits name the owning requester port.
   localparam logic [1:0] ID_PREFIX_VLSU   = 2'b00;
   localparam logic [1:0] ID_PREFIX_ICACHE = 2'b01;

   typedef enum logic [1:0] {
      READ_REQ  = 2'd0,
      READ_RSP  = 2'd1,
      WRITE_REQ = 2'd2,
      WRITE_RSP = 2'd3
   } access_type_t;

   typedef struct packed {
      logic                        vld;
      access_type_t                access_type;
      logic [ACCESS_ID_WIDTH-1:0]  access_id;
      logic [ADDR_WIDTH-1:0]       addr;
      logic [2:0]                  access_length;
      logic [DATA_WIDTH/8-1:0]     byte_en;
      logic [DATA_WIDTH-1:0]       data;
   } request_t;

   function automatic logic [1:0] id_prefix(input logic [ACCESS_ID_WIDTH-1:0] id);
      return id[ACCESS_ID_WIDTH-1:ACCESS_ID_WIDTH-2];
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin selector: the first valid requester at or after
// rr_ptr (wrapping) wins, reported one-hot.
module rr_picker #(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     vld,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N-1:0]     winner,
   output logic             any
);

   // Outer loop walks search order from rr_ptr; the first hit blocks the rest.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!any && vld[j] && (((int'(rr_ptr) + i) % N) == j)) begin
               winner[j] = 1'b1;
               any       = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter from up to four requesters onto one memory request
// channel, with a one-entry output slot and prefix-steered response routing.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  request_t             req [NUM_PORTS],
   output logic [NUM_PORTS-1:0] grant,
   output request_t             rsp [NUM_PORTS],
   output request_t             mem_req,
   input  logic                 mem_ready,
   input  request_t             mem_rsp,
   output logic [7:0]           drop_count
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     next_ptr;
   logic [NUM_PORTS-1:0] req_vld;
   logic [NUM_PORTS-1:0] winner;
   logic                 any_vld;
   logic                 slot_free;
   request_t             win_req;
   logic [1:0]           rsp_prefix;

   always_comb begin
      req_vld = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         req_vld[p] = req[p].vld;
      end
   end

   rr_picker #(
      .N     (NUM_PORTS),
      .PTR_W (PTR_W)
   ) u_picker (
      .vld    (req_vld),
      .rr_ptr (rr_ptr),
      .winner (winner),
      .any    (any_vld)
   );

   assign slot_free = !mem_req.vld || mem_ready;

   // Grants are held low while reset is asserted so no requester believes it
   // was accepted by a slot that is being cleared.
   assign grant = (reset && slot_free) ? winner : '0;

   always_comb begin
      win_req  = '0;
      next_ptr = rr_ptr;
      for (int j = 0; j < NUM_PORTS; j++) begin
         if (winner[j]) begin
            win_req  = req[j];
            next_ptr = PTR_W'((j + 1) % NUM_PORTS);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req <= '0;
         rr_ptr  <= '0;
      end else if (slot_free) begin
         if (any_vld) begin
            mem_req <= win_req;
            rr_ptr  <= next_ptr;
         end else begin
            mem_req.vld <= 1'b0;
         end
      end
   end

   assign rsp_prefix = id_prefix(mem_rsp.access_id);

   // Responses cannot be stalled, so prefixes with no owning port are counted
   // and discarded rather than held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            rsp[p] <= '0;
         end
         drop_count <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (mem_rsp.vld && (int'(rsp_prefix) == p)) begin
               rsp[p] <= mem_rsp;
            end else begin
               rsp[p].vld <= 1'b0;
            end
         end
         if (mem_rsp.vld && (int'(rsp_prefix) >= NUM_PORTS) && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int NP = 2;

   logic          clk = 1'b0;
   logic          reset;
   request_t      req [NP];
   logic [NP-1:0] grant;
   request_t      rsp [NP];
   request_t      mem_req;
   logic          mem_ready;
   request_t      mem_rsp;
   logic [7:0]    drop_count;

   int tests_run    = 0;
   int tests_failed = 0;

   request_t      m_mem_req;
   int            m_rr;
   request_t      m_rsp [NP];
   int            m_drop;
   logic [NP-1:0] m_grant;

   mem_arbiter #(.NUM_PORTS(NP)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .grant      (grant),
      .rsp        (rsp),
      .mem_req    (mem_req),
      .mem_ready  (mem_ready),
      .mem_rsp    (mem_rsp),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   function automatic request_t rand_req(input int port);
      request_t r;
      r.vld           = 1'b1;
      r.access_type   = access_type_t'(2'($urandom_range(0, 3)));
      r.access_id     = {2'(port), 6'($urandom)};
      r.addr          = $urandom;
      r.access_length = 3'($urandom);
      r.byte_en       = 4'($urandom);
      r.data          = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      m_mem_req = '0;
      m_rr      = 0;
      m_drop    = 0;
      m_grant   = '0;
      for (int p = 0; p < NP; p++) m_rsp[p] = '0;
   endtask

   task automatic model_grant();
      int p;
      m_grant = '0;
      if (reset && (!m_mem_req.vld || mem_ready)) begin
         for (int k = 0; k < NP; k++) begin
            p = (m_rr + k) % NP;
            if (m_grant == '0 && req[p].vld) m_grant[p] = 1'b1;
         end
      end
   endtask

   task automatic model_edge();
      int  pre;
      logic free;
      free = !m_mem_req.vld || mem_ready;
      if (free) begin
         if (m_grant == '0) m_mem_req.vld = 1'b0;
         for (int p = 0; p < NP; p++) begin
            if (m_grant[p]) begin
               m_mem_req = req[p];
               m_rr      = (p + 1) % NP;
            end
         end
      end
      for (int p = 0; p < NP; p++) m_rsp[p].vld = 1'b0;
      if (mem_rsp.vld) begin
         pre = int'(mem_rsp.access_id[7:6]);
         if (pre < NP) m_rsp[pre] = mem_rsp;
         else if (m_drop < 255) m_drop = m_drop + 1;
      end
   endtask

   task automatic settle();
      #1;
      model_grant();
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      for (int p = 0; p < NP; p++) req[p] = '0;
      mem_rsp   = '0;
      mem_ready = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      request_t r0;
      req[0] = rand_req(0);
      req[1] = rand_req(1);
      mem_ready = 1'b1;
      mem_rsp   = '0;
      reset     = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (mem_req.vld !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_mem_req_vld: got %b expected 0", mem_req.vld);
      end
      tests_run++;
      if (grant !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_grant: got %b expected 00", grant);
      end
      tests_run++;
      if (drop_count !== 8'd0 || rsp[0].vld !== 1'b0 || rsp[1].vld !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_rsp_drop: got drop=%0d rsp_vld=%b%b expected 0 00",
                  drop_count, rsp[1].vld, rsp[0].vld);
      end
      reset = 1'b1;
      settle();
      tests_run++;
      if (grant !== 2'b01) begin
         tests_failed++;
         $display("[TB] FAIL reset_first_grant: got %b expected 01", grant);
      end
      r0 = req[0];
      tick();
      tests_run++;
      if (mem_req !== r0) begin
         tests_failed++;
         $display("[TB] FAIL reset_first_mem_req: got %h expected %h", mem_req, r0);
      end
   endtask

   task automatic test_fairness();
      logic [NP-1:0] exp_g;
      request_t      sent;
      do_reset();
      req[0] = rand_req(0);
      req[1] = rand_req(1);
      for (int k = 0; k < 6; k++) begin
         settle();
         exp_g        = '0;
         exp_g[k % 2] = 1'b1;
         tests_run++;
         if (grant !== exp_g) begin
            tests_failed++;
            $display("[TB] FAIL fair_grant[%0d]: got %b expected %b", k, grant, exp_g);
         end
         sent = req[k % 2];
         tick();
         tests_run++;
         if (mem_req !== sent || mem_req.access_id[7:6] !== 2'(k % 2)) begin
            tests_failed++;
            $display("[TB] FAIL fair_mem_req[%0d]: got %h expected %h", k, mem_req, sent);
         end
         req[k % 2] = rand_req(k % 2);
      end
   endtask

   task automatic test_stall();
      request_t r, r1;
      do_reset();
      r      = rand_req(0);
      r.addr = 32'h40;
      req[0] = r;
      settle();
      tests_run++;
      if (grant !== 2'b01) begin
         tests_failed++;
         $display("[TB] FAIL stall_first_grant: got %b expected 01", grant);
      end
      tick();
      req[0]    = rand_req(0);
      req[1]    = rand_req(1);
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         tests_run++;
         if (grant !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL stall_grant[%0d]: got %b expected 00", k, grant);
         end
         tick();
         tests_run++;
         if (mem_req !== r || mem_req.addr !== 32'h40) begin
            tests_failed++;
            $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", k, mem_req, r);
         end
      end
      mem_ready = 1'b1;
      settle();
      tests_run++;
      if (grant !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL stall_release_grant: got %b expected 10", grant);
      end
      r1 = req[1];
      tick();
      tests_run++;
      if (mem_req !== r1) begin
         tests_failed++;
         $display("[TB] FAIL stall_release_mem_req: got %h expected %h", mem_req, r1);
      end
      req[0].vld = 1'b0;
      req[1].vld = 1'b0;
   endtask

   task automatic test_icache_burst();
      request_t sent, rs;
      do_reset();
      for (int i = 0; i <= 32; i++) begin
         if (i < 32) begin
            req[1]           = rand_req(1);
            req[1].access_id = 8'(64 + i);
         end else begin
            req[1] = '0;
         end
         if (i > 0) begin
            mem_rsp           = rand_req(1);
            mem_rsp.access_id = 8'(64 + i - 1);
         end else begin
            mem_rsp = '0;
         end
         settle();
         if (i < 32) begin
            tests_run++;
            if (grant !== 2'b10) begin
               tests_failed++;
               $display("[TB] FAIL burst_grant[%0d]: got %b expected 10", i, grant);
            end
         end
         sent = req[1];
         rs   = mem_rsp;
         tick();
         tests_run++;
         if (i < 32) begin
            if (mem_req !== sent || mem_req.access_id !== 8'(64 + i)) begin
               tests_failed++;
               $display("[TB] FAIL burst_mem_req[%0d]: got %h expected %h", i, mem_req, sent);
            end
         end else if (mem_req.vld !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL burst_idle_vld: got %b expected 0", mem_req.vld);
         end
         if (i > 0) begin
            tests_run++;
            if (rsp[1] !== rs || rsp[1].access_id !== 8'(64 + i - 1) || rsp[0].vld !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL burst_rsp[%0d]: got rsp1=%h rsp0_vld=%b expected %h 0",
                        i, rsp[1], rsp[0].vld, rs);
            end
         end
      end
      mem_rsp = '0;
   endtask

   task automatic test_bad_prefix();
      do_reset();
      mem_rsp = rand_req(3);
      settle();
      tick();
      tests_run++;
      if (rsp[0].vld !== 1'b0 || rsp[1].vld !== 1'b0 || drop_count !== 8'd1) begin
         tests_failed++;
         $display("[TB] FAIL bad_prefix_first: got rsp_vld=%b%b drop=%0d expected 00 1",
                  rsp[1].vld, rsp[0].vld, drop_count);
      end
      for (int k = 0; k < 299; k++) begin
         mem_rsp = rand_req(2 + $urandom_range(0, 1));
         settle();
         tick();
      end
      tests_run++;
      if (drop_count !== 8'd255 || m_drop != 255) begin
         tests_failed++;
         $display("[TB] FAIL bad_prefix_saturate: got %0d expected 255", drop_count);
      end
      mem_rsp = '0;
   endtask

   task automatic test_simultaneous();
      request_t s, rs;
      do_reset();
      req[0]  = rand_req(0);
      mem_rsp = rand_req(1);
      settle();
      tests_run++;
      if (grant !== 2'b01) begin
         tests_failed++;
         $display("[TB] FAIL simul_grant: got %b expected 01", grant);
      end
      s  = req[0];
      rs = mem_rsp;
      tick();
      tests_run++;
      if (mem_req !== s) begin
         tests_failed++;
         $display("[TB] FAIL simul_mem_req: got %h expected %h", mem_req, s);
      end
      tests_run++;
      if (rsp[1] !== rs || rsp[0].vld !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL simul_rsp: got %h expected %h", rsp[1], rs);
      end
      req[0]  = '0;
      mem_rsp = '0;
   endtask

   task automatic test_random();
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int p = 0; p < NP; p++) begin
            if (!req[p].vld || m_grant[p])
               req[p] = ($urandom_range(0, 9) < 6) ? rand_req(p) : '0;
         end
         mem_ready = ($urandom_range(0, 9) < 7);
         mem_rsp   = ($urandom_range(0, 1) == 1) ? rand_req($urandom_range(0, 3)) : '0;
         settle();
         if (cyc == 300) begin
            #1 reset = 1'b0;
            #1;
            tests_run++;
            if (mem_req.vld !== 1'b0 || drop_count !== 8'd0) begin
               tests_failed++;
               $display("[TB] FAIL rand_async_reset: got vld=%b drop=%0d expected 0 0",
                        mem_req.vld, drop_count);
            end
            model_reset();
            #1 reset = 1'b1;
            settle();
         end
         tests_run++;
         if (grant !== m_grant) begin
            tests_failed++;
            $display("[TB] FAIL rand_grant[%0d]: got %b expected %b", cyc, grant, m_grant);
         end
         tick();
         tests_run++;
         if (mem_req.vld !== m_mem_req.vld || (m_mem_req.vld && mem_req !== m_mem_req)) begin
            tests_failed++;
            $display("[TB] FAIL rand_mem_req[%0d]: got %h expected %h", cyc, mem_req, m_mem_req);
         end
         for (int p = 0; p < NP; p++) begin
            tests_run++;
            if (rsp[p].vld !== m_rsp[p].vld || (m_rsp[p].vld && rsp[p] !== m_rsp[p])) begin
               tests_failed++;
               $display("[TB] FAIL rand_rsp%0d[%0d]: got %h expected %h", p, cyc, rsp[p], m_rsp[p]);
            end
         end
         tests_run++;
         if (drop_count !== 8'(m_drop)) begin
            tests_failed++;
            $display("[TB] FAIL rand_drop[%0d]: got %0d expected %0d", cyc, drop_count, m_drop);
         end
      end
   endtask

   initial begin
      reset     = 1'b0;
      mem_ready = 1'b1;
      mem_rsp   = '0;
      for (int p = 0; p < NP; p++) req[p] = '0;
      model_reset();
      test_reset();
      test_fairness();
      test_stall();
      test_icache_burst();
      test_bad_prefix();
      test_simultaneous();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
